// File: rtl/projeto_pkg.sv
// Shared types and constants for the Horner-form polynomial evaluator.
package projeto_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned PWIDTH = 2 * WIDTH;
  localparam int unsigned SWIDTH = WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL1 = 3'd1,
    ADD1 = 3'd2,
    MUL2 = 3'd3,
    ADD2 = 3'd4,
    DONE = 3'd5
  } state_e;

  // Control word from the FSM to the datapath.
  typedef struct packed {
    logic load_op;  // latch X/A/B/C and clear the overflow accumulator
    logic sel_mul;  // multiplicand: 0 = A, 1 = R
    logic sel_add;  // step result: 0 = multiplier, 1 = adder
    logic sel_c;    // adder addend: 0 = B, 1 = C
    logic load_r;   // write the step result into R
    logic load_out; // write the step result into resultado/overflow
  } ctrl_t;

endpackage

// File: rtl/projeto_datapath.sv
// Operand registers, accumulator R, shared multiplier/adder and overflow tracking.
module projeto_datapath
  import projeto_pkg::*;
(
  input  logic             ck,
  input  logic             rst,
  input  ctrl_t            ctrl_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] resultado_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0]  x_q, a_q, b_q, c_q, r_q, res_q;
  logic              ov_q, ovf_q;
  logic [WIDTH-1:0]  mul_a_c, addend_c, step_val_c;
  logic [PWIDTH-1:0] prod_c;
  logic [SWIDTH-1:0] sum_c;
  logic              step_ov_c;

  // Shared multiplier and adder; the control word picks which feeds the step.
  always_comb begin
    mul_a_c    = ctrl_i.sel_mul ? r_q : a_q;
    addend_c   = ctrl_i.sel_c ? c_q : b_q;
    prod_c     = PWIDTH'(mul_a_c) * PWIDTH'(x_q);
    sum_c      = SWIDTH'(r_q) + SWIDTH'(addend_c);
    step_val_c = ctrl_i.sel_add ? sum_c[WIDTH-1:0] : prod_c[WIDTH-1:0];
    step_ov_c  = ctrl_i.sel_add ? sum_c[WIDTH] : (|prod_c[PWIDTH-1:WIDTH]);
  end

  // Datapath registers; the sticky overflow folds in every step's high bits.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      r_q   <= '0;
      ov_q  <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (ctrl_i.load_op) begin
        x_q  <= x_i;
        a_q  <= a_i;
        b_q  <= b_i;
        c_q  <= c_i;
        ov_q <= 1'b0;
      end
      if (ctrl_i.load_r) begin
        r_q  <= step_val_c;
        ov_q <= ov_q | step_ov_c;
      end
      if (ctrl_i.load_out) begin
        res_q <= step_val_c;
        ovf_q <= ov_q | step_ov_c;
      end
    end
  end

  assign resultado_o = res_q;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/projeto.sv
// Sequential evaluator of A*X^2 + B*X + C: control FSM plus datapath.
module projeto
  import projeto_pkg::*;
(
  input  logic             ck,
  input  logic             rst,
  input  logic             inicio,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             pronto,
  output logic             overflow,
  output logic [WIDTH-1:0] resultado
);

  state_e state_q, state_d;
  ctrl_t  ctrl_c;
  logic   pronto_q;

  // State register; pronto is registered alongside so it is high exactly in DONE.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pronto_q <= (state_d == DONE);
    end
  end

  // Next-state and control word; inicio only matters in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      IDLE, DONE: begin
        if (inicio) begin
          ctrl_c.load_op = 1'b1;
          state_d        = MUL1;
        end
      end
      MUL1: begin
        ctrl_c.load_r = 1'b1;
        state_d       = ADD1;
      end
      ADD1: begin
        ctrl_c.sel_add = 1'b1;
        ctrl_c.load_r  = 1'b1;
        state_d        = MUL2;
      end
      MUL2: begin
        ctrl_c.sel_mul = 1'b1;
        ctrl_c.load_r  = 1'b1;
        state_d        = ADD2;
      end
      ADD2: begin
        ctrl_c.sel_add  = 1'b1;
        ctrl_c.sel_c    = 1'b1;
        ctrl_c.load_out = 1'b1;
        state_d         = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  projeto_datapath u_datapath (
    .ck          (ck),
    .rst         (rst),
    .ctrl_i      (ctrl_c),
    .x_i         (X),
    .a_i         (A),
    .b_i         (B),
    .c_i         (C),
    .resultado_o (resultado),
    .overflow_o  (overflow)
  );

  assign pronto = pronto_q;

endmodule

// File: tb/tb_projeto.sv
// Self-checking bench for projeto against a plain-arithmetic polynomial model.
module tb_projeto;

  logic        ck, rst, inicio;
  logic [15:0] X, A, B, C;
  logic        pronto, overflow;
  logic [15:0] resultado;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_res;
  logic        exp_ov;

  projeto dut (
    .ck        (ck),
    .rst       (rst),
    .inicio    (inicio),
    .X         (X),
    .A         (A),
    .B         (B),
    .C         (C),
    .pronto    (pronto),
    .overflow  (overflow),
    .resultado (resultado)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: Horner evaluation with wide integers, flagging any step above 16 bits.
  function automatic logic [16:0] model(input logic [15:0] x, a, b, c);
    longint unsigned r;
    bit ov;
    r  = longint'(a) * longint'(x);
    ov = (r > 65535);
    r  = r % 65536;
    r  = r + longint'(b);
    ov = ov | (r > 65535);
    r  = r % 65536;
    r  = r * longint'(x);
    ov = ov | (r > 65535);
    r  = r % 65536;
    r  = r + longint'(c);
    ov = ov | (r > 65535);
    r  = r % 65536;
    return {ov, r[15:0]};
  endfunction

  // One computation started by a single inicio sample; checks busy, hold and result.
  task automatic run_vec(input logic [15:0] x, a, b, c, input bit poke);
    logic [16:0] m;
    m = model(x, a, b, c);
    @(negedge ck);
    X = x; A = a; B = b; C = c; inicio = 1'b1;
    @(posedge ck);
    for (int i = 0; i < 4; i++) begin
      @(negedge ck);
      X = 16'($urandom); A = 16'($urandom); B = 16'($urandom); C = 16'($urandom);
      inicio = (poke && i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      check_eq("busy_pronto", {31'd0, pronto}, 32'd0);
      check_eq("hold_res", {16'd0, resultado}, {16'd0, exp_res});
      check_eq("hold_ovf", {31'd0, overflow}, {31'd0, exp_ov});
    end
    @(negedge ck);
    exp_res = m[15:0];
    exp_ov  = m[16];
    check_eq("done_pronto", {31'd0, pronto}, 32'd1);
    check_eq("done_res", {16'd0, resultado}, {16'd0, exp_res});
    check_eq("done_ovf", {31'd0, overflow}, {31'd0, exp_ov});
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_pronto"}, {31'd0, pronto}, 32'd0);
    check_eq({tag, "_res"}, {16'd0, resultado}, 32'd0);
    check_eq({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    logic [16:0] m1, m2;
    logic [15:0] x0, x1;
    rst = 1'b1; inicio = 1'b0; X = '0; A = '0; B = '0; C = '0;
    exp_res = '0; exp_ov = 1'b0;
    repeat (2) @(negedge ck);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge ck);
    check_idle_outputs("idle");

    // Reference vectors with known answers.
    run_vec(16'd23, 16'd38, 16'd333, 16'd4902, 1'b1);
    check_eq("ref_res", {16'd0, resultado}, 32'd32663);
    repeat (3) @(negedge ck);
    check_eq("hold_pronto", {31'd0, pronto}, 32'd1);
    check_eq("hold_val", {16'd0, resultado}, 32'd32663);

    // Restart from DONE: previous result held until the new DONE.
    run_vec(16'd2, 16'd1, 16'd1, 16'd1, 1'b0);
    check_eq("restart_res", {16'd0, resultado}, 32'd7);

    run_vec(16'd256, 16'd1, 16'd0, 16'd0, 1'b1);
    check_eq("mul2_ovf", {31'd0, overflow}, 32'd1);
    run_vec(16'd1, 16'hFFFF, 16'd1, 16'd5, 1'b1);
    check_eq("add1_ovf", {31'd0, overflow}, 32'd1);
    check_eq("add1_res", {16'd0, resultado}, 32'd5);

    // Asynchronous reset mid-computation.
    @(negedge ck);
    X = 16'd23; A = 16'd38; B = 16'd333; C = 16'd4902; inicio = 1'b1;
    @(posedge ck);
    @(negedge ck); inicio = 1'b0;
    @(posedge ck);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_rst");
    @(negedge ck); rst = 1'b0;
    exp_res = '0; exp_ov = 1'b0;
    repeat (3) @(negedge ck);
    check_idle_outputs("post_rst_idle");
    run_vec(16'd23, 16'd38, 16'd333, 16'd4902, 1'b0);

    // Randomised vectors, mixing small operands with full-range ones.
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0)
        run_vec(16'($urandom_range(0, 40)), 16'($urandom_range(0, 40)),
                16'($urandom_range(0, 2000)), 16'($urandom_range(0, 30000)), 1'b1);
      else
        run_vec(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    end

    // inicio held high: 5-cycle period, one pronto cycle per result, X latched.
    x0 = 16'd23; x1 = 16'd7;
    m1 = model(x0, 16'd38, 16'd333, 16'd4902);
    m2 = model(x1, 16'd38, 16'd333, 16'd4902);
    @(negedge ck);
    X = x0; A = 16'd38; B = 16'd333; C = 16'd4902; inicio = 1'b1;
    @(posedge ck);
    for (int k = 0; k < 10; k++) begin
      @(negedge ck);
      if (k == 1) X = x1;
      check_eq("cont_pronto", {31'd0, pronto}, (k % 5 == 4) ? 32'd1 : 32'd0);
      if (k == 4) check_eq("cont_res1", {16'd0, resultado}, {16'd0, m1[15:0]});
      if (k == 9) check_eq("cont_res2", {16'd0, resultado}, {16'd0, m2[15:0]});
      if (k == 9) inicio = 1'b0;
    end
    repeat (3) @(negedge ck);
    check_eq("cont_stay_done", {31'd0, pronto}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
